// File: rtl/led_code_decoder_if.sv
// rtl/led_code_decoder_if.sv - pixel code input and LED matrix drive bundle
// for led_code_decoder.
interface led_code_decoder_if;
  logic [9:0]  code;
  logic [15:0] row;
  logic [7:0]  col;
  logic [2:0]  ball_x;
  logic [3:0]  ball_y;
  logic        ball_valid;

  modport master (
    output code,
    input  row, col, ball_x, ball_y, ball_valid
  );

  modport slave (
    input  code,
    output row, col, ball_x, ball_y, ball_valid
  );
endinterface

// File: rtl/led_code_decoder.sv
// rtl/led_code_decoder.sv - double-buffered 16x8 bar/ball pixel frame decoder
// with row-scanned LED output; optional ball blink via LED_CODE_DECODER_BLINK_EN.
module led_code_decoder #(
  parameter logic [21:0] FRAME_LEN = 22'd256128,
  parameter logic [15:0] SCAN_DIV  = 16'd5000
) (
  input logic             clk,
  input logic             rst_n,
  led_code_decoder_if.slave bus
);

  logic [9:0]       code_q;
  logic [21:0]      frame_cnt;
  logic [15:0]      scan_cnt;
  logic [3:0]       row_idx;
  logic [3:0]       row_nxt;
  logic             swap;
  logic             scan_wrap;
  logic             wr_ball;
  logic [15:0][7:0] bar_back;
  logic [15:0][7:0] ball_back;
  logic [15:0][7:0] bar_disp;
  logic [15:0][7:0] ball_disp;
  logic [15:0][7:0] bar_set;
  logic [15:0][7:0] ball_set;
  logic [2:0]       trk_x;
  logic [3:0]       trk_y;
  logic             trk_seen;
  logic [15:0]      row_q;
  logic [7:0]       col_q;
  logic [2:0]       ball_x_q;
  logic [3:0]       ball_y_q;
  logic             ball_valid_q;
  logic [7:0]       ball_term;
  logic             unused_code_bit;

  assign unused_code_bit = code_q[7];

  always_comb begin
    swap      = (frame_cnt == FRAME_LEN - 22'd1);
    scan_wrap = (scan_cnt == SCAN_DIV - 16'd1);
    row_nxt   = scan_wrap ? row_idx + 4'd1 : row_idx;
    wr_ball   = code_q[8];
    bar_set   = '0;
    ball_set  = '0;
    if (code_q[9]) bar_set[code_q[6:3]][code_q[2:0]] = 1'b1;
    if (code_q[8]) ball_set[code_q[6:3]][code_q[2:0]] = 1'b1;
  end

`ifdef LED_CODE_DECODER_BLINK_EN
  logic blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else if (swap) begin
      blink <= ~blink;
    end
  end

  assign ball_term = ball_disp[row_idx] & {8{blink}};
`else
  assign ball_term = ball_disp[row_idx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      frame_cnt <= '0;
      scan_cnt  <= '0;
      row_idx   <= '0;
    end else begin
      code_q    <= bus.code;
      frame_cnt <= swap ? 22'd0 : frame_cnt + 22'd1;
      scan_cnt  <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      row_idx   <= row_nxt;
    end
  end

  // A write landing on the swap cycle seeds the freshly cleared back planes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_back  <= '0;
      ball_back <= '0;
      bar_disp  <= '0;
      ball_disp <= '0;
    end else if (swap) begin
      bar_disp  <= bar_back;
      ball_disp <= ball_back;
      bar_back  <= bar_set;
      ball_back <= ball_set;
    end else begin
      bar_back  <= bar_back | bar_set;
      ball_back <= ball_back | ball_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_x        <= '0;
      trk_y        <= '0;
      trk_seen     <= 1'b0;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      ball_valid_q <= 1'b0;
    end else begin
      if (swap) begin
        trk_seen     <= wr_ball;
        trk_x        <= wr_ball ? code_q[2:0] : 3'd0;
        trk_y        <= wr_ball ? code_q[6:3] : 4'd0;
        ball_valid_q <= trk_seen;
        if (trk_seen) begin
          ball_x_q <= trk_x;
          ball_y_q <= trk_y;
        end
      end else if (wr_ball) begin
        trk_seen <= 1'b1;
        trk_x    <= code_q[2:0];
        trk_y    <= code_q[6:3];
      end
    end
  end

  // row_q tracks the index being loaded so it is one-hot of row_idx at all times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= 16'h0001 << row_nxt;
      col_q <= bar_disp[row_idx] | ball_term;
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.ball_valid = ball_valid_q;

endmodule

// File: doc/led_code_decoder.md
LED_CODE_DECODER -- requirements
Module: led_code_decoder

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 22'd256128, giving the frame accumulation period in CLK cycles.
REQ-002 The block SHALL have parameter SCAN_DIV, default 16'd5000, giving the CLK cycles per matrix row.
REQ-003 CLK  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 CODEin  input  10  pixel code: bit9 bar plane, bit8 ball plane, bit7 ignored, bits6:3 row 0-15, bits2:0 column 0-7; value 0 means idle.
REQ-006 ROWout  output  16  one-hot, active-high row enable.
REQ-007 COLout  output  8  active-high column data for the enabled row; bit n is column n.
REQ-008 BALLX  output  3  column of the last ball pixel latched at frame swap.
REQ-009 BALLY  output  4  row of the last ball pixel latched at frame swap.
REQ-010 BALL_VALID  output  1  high when the displayed frame contains at least one ball pixel.

Function
REQ-011 The block SHALL register CODEin once; a registered code SHALL be a write only if bit9 or bit8 is 1.
REQ-012 A write SHALL set the addressed pixel in the back bar plane when bit9 is 1 and in the back ball plane when bit8 is 1; both planes SHALL be set when both bits are 1.
REQ-013 The back planes SHALL be written one cycle after CLK samples CODEin, giving two cycles of write latency.
REQ-014 Repeated identical codes SHALL be idempotent, because pixel set is an OR.
REQ-015 A frame counter SHALL count 0 to FRAME_LEN-1 and wrap; the cycle at FRAME_LEN-1 is the swap cycle.
REQ-016 On the swap cycle, the display planes SHALL load the back planes, the back planes SHALL clear, and BALLX, BALLY and BALL_VALID SHALL load the ball-tracker values.
REQ-017 If a write coincides with the swap cycle, its pixel SHALL appear in the newly cleared back planes and SHALL NOT appear in the display planes loaded that cycle.
REQ-018 The ball tracker SHALL hold the coordinates of the most recent ball-plane write in the current frame, plus a seen flag; it SHALL clear on the swap cycle, applying the same precedence as REQ-017.
REQ-019 On the swap cycle, a frame with no ball writes SHALL give BALL_VALID=0 and SHALL leave BALLX and BALLY unchanged.
REQ-020 A scan prescaler SHALL count 0 to SCAN_DIV-1; at wrap, the row index SHALL increment modulo 16 (15 to 0).
REQ-021 ROWout SHALL equal 1 shifted left by the row index.
REQ-022 COLout SHALL equal display_bar[row] OR ball_term[row], both registered, with one cycle of latency from a row index change.
REQ-023 A display swap SHALL affect COLout no later than one cycle after the swap, including mid-row.
REQ-024 Scan timing SHALL be independent of CODEin activity.

Reset
REQ-025 While RSTn=0, all planes, counters, the row index and the ball tracker SHALL be 0.
REQ-026 While RSTn=0, ROWout, COLout, BALLX, BALLY and BALL_VALID SHALL be 0.
REQ-027 After reset release, ROWout SHALL become 16'h0001 on the first clock.
REQ-028 Reset asserted mid-frame SHALL discard the partially accumulated frame.

Configuration
REQ-029 With macro LED_CODE_DECODER_BLINK_EN defined, a blink flag SHALL toggle on every swap cycle.
REQ-030 With LED_CODE_DECODER_BLINK_EN defined, ball_term SHALL be display_ball[row] AND blink, and the blink flag SHALL reset to 0.
REQ-031 Without LED_CODE_DECODER_BLINK_EN, ball_term SHALL be display_ball[row], no blink register SHALL exist, and ball pixels SHALL be steady.

Verification (FRAME_LEN=64 and SCAN_DIV=4 for all scenarios)
REQ-032 Apply reset, then release with CODEin=0 for 2 frames -> COLout=0, BALL_VALID=0, ROWout steps 0001, 0002, ... every 4 cycles and wraps 8000 to 0001.
REQ-033 Drive CODEin=10'b1001101000 (bar, row 13, column 0) for 5 cycles in frame 0 -> after the swap, COLout=8'h01 while ROWout=16'h2000, and 0 on all other rows.
REQ-034 Drive ball code 10'b0100100101 (row 4, column 5) and then 10'b0100111010 (row 7, column 2) in one frame -> after the swap, BALLX=2, BALLY=7, BALL_VALID=1, with both pixels lit.
REQ-035 Drive a bar write so that it is registered exactly on the swap cycle -> the pixel is absent from the frame just swapped in and present after the next swap.
REQ-036 Drive code 10'b0001111111 (no plane bit) -> no pixel set and BALL_VALID unchanged; then assert RSTn=0 mid-frame after a ball write -> all outputs 0 and the next frame is empty.
REQ-037 With LED_CODE_DECODER_BLINK_EN, drive the same ball pixel every frame -> it is lit in alternate frames only; without the macro it is lit in every frame.
